display_list_sequencer: RTL and testbench

Per-scanline register sequencer that sits between the CPU bus and the video/peripheral register write port. During each horizontal blank it fetches a list of (address, data) write commands from memory and replays them into the video registers (colours, playfield, player graphics, positions), giving mid-frame changes without CPU polling of the blank waits. It also arbitrates the single register write port between the CPU and the list engine, stalling the CPU when the port is owned by the engine.

---
 rtl/display_list_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_display_list_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_list_sequencer.sv
// rtl/display_list_sequencer.sv - per-scanline display list replay engine with CPU register port arbitration
// Fetches (address, data) entries during hblank and replays them into the video register write port.
module display_list_sequencer #(
    parameter int MAX_WRITES = 8
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        list_enable,
    input  logic [15:0] list_base,
    input  logic        in_hblank,
    input  logic        in_vblank,
    input  logic        cpu_write_enable,
    input  logic [5:0]  cpu_address,
    input  logic [7:0]  cpu_data,
    output logic        cpu_busy,
    output logic [15:0] mem_address,
    output logic        mem_read,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic        periph_write_enable,
    output logic [5:0]  periph_address,
    output logic [7:0]  periph_data,
    output logic        overrun
);

    localparam int WD_W = $clog2(MAX_WRITES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_CMD,
        FETCH_DATA,
        WRITE
    } state_t;

    state_t state, next_state;

    logic [15:0]     ptr;
    logic            hblank_d, vblank_d;
    logic            cmd_last, cmd_nop;
    logic [5:0]      cmd_addr;
    logic [7:0]      cmd_data;
    logic [WD_W-1:0] writes_done;
    logic            drain;
    logic            overrun_q;

    logic            hold_valid;
    logic [5:0]      hold_addr;
    logic [7:0]      hold_data;
    logic [5:0]      last_addr;
    logic [7:0]      last_data;

    logic hblank_rise, hblank_fall, vblank_rise;
    logic eng_write, write_blocked, cpu_issue;

    always_comb begin
        hblank_rise   = in_hblank & ~hblank_d;
        hblank_fall   = ~in_hblank & hblank_d;
        vblank_rise   = in_vblank & ~vblank_d;
        eng_write     = (state == WRITE) && !cmd_nop && !drain
                        && (writes_done < WD_W'(MAX_WRITES));
        write_blocked = (state == WRITE) && !cmd_nop && !eng_write;
        // The engine owns the port for the whole WRITE cycle, even for a suppressed entry.
        cpu_issue     = hold_valid && (state != WRITE);
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        mem_read    = 1'b0;
        mem_address = 16'h0000;
        case (state)
            IDLE: begin
                if (hblank_rise) begin
                    next_state = FETCH_CMD;
                end
            end
            FETCH_CMD: begin
                mem_read    = 1'b1;
                mem_address = ptr;
                if (mem_ready) begin
                    next_state = FETCH_DATA;
                end
            end
            FETCH_DATA: begin
                mem_read    = 1'b1;
                mem_address = ptr + 16'd1;
                if (mem_ready) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = cmd_last ? IDLE : FETCH_CMD;
            end
            default: next_state = IDLE;
        endcase
        if (vblank_rise && state != IDLE) begin
            next_state = IDLE;
        end
        if (!list_enable) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            ptr         <= 16'h0000;
            hblank_d    <= 1'b0;
            vblank_d    <= 1'b0;
            cmd_last    <= 1'b0;
            cmd_nop     <= 1'b0;
            cmd_addr    <= 6'h00;
            cmd_data    <= 8'h00;
            writes_done <= '0;
            drain       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            hblank_d <= in_hblank;
            vblank_d <= in_vblank;
            if (state == IDLE && hblank_rise) begin
                writes_done <= '0;
                drain       <= 1'b0;
            end
            if (state == FETCH_CMD && mem_ready) begin
                cmd_last <= mem_data[7];
                cmd_nop  <= mem_data[6];
                cmd_addr <= mem_data[5:0];
            end
            if (state == FETCH_DATA && mem_ready) begin
                cmd_data <= mem_data;
            end
            // Reload wins over the advance so a new frame always starts at list_base.
            if (vblank_rise) begin
                ptr <= list_base;
            end else if (state == FETCH_DATA && mem_ready && list_enable) begin
                ptr <= ptr + 16'd2;
            end
            if (eng_write) begin
                writes_done <= writes_done + 1'b1;
            end
            if (hblank_fall && state != IDLE) begin
                drain <= 1'b1;
            end
            if (vblank_rise) begin
                overrun_q <= 1'b0;
            end else if ((hblank_fall && state != IDLE) || write_blocked) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_addr  <= 6'h00;
            hold_data  <= 8'h00;
        end else if (cpu_issue) begin
            hold_valid <= 1'b0;
        end else if (cpu_write_enable && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_addr  <= cpu_address;
            hold_data  <= cpu_data;
        end
    end

    always_comb begin
        periph_write_enable = eng_write | cpu_issue;
        periph_address      = last_addr;
        periph_data         = last_data;
        if (eng_write) begin
            periph_address = cmd_addr;
            periph_data    = cmd_data;
        end else if (cpu_issue) begin
            periph_address = hold_addr;
            periph_data    = hold_data;
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            last_addr <= 6'h00;
            last_data <= 8'h00;
        end else if (periph_write_enable) begin
            last_addr <= periph_address;
            last_data <= periph_data;
        end
    end

    assign cpu_busy = hold_valid;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_display_list_sequencer.sv
// tb/tb_display_list_sequencer.sv - self-checking bench for display_list_sequencer
module tb_display_list_sequencer;

    logic        raw_clk = 1'b0;
    logic        reset;
    logic        list_enable;
    logic [15:0] list_base;
    logic        in_hblank;
    logic        in_vblank;
    logic        cpu_write_enable;
    logic [5:0]  cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_busy;
    logic [15:0] mem_address;
    logic        mem_read;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        periph_write_enable;
    logic [5:0]  periph_address;
    logic [7:0]  periph_data;
    logic        overrun;

    logic [7:0] mem_model [0:65535];

    display_list_sequencer #(.MAX_WRITES(8)) dut (
        .raw_clk             (raw_clk),
        .reset               (reset),
        .list_enable         (list_enable),
        .list_base           (list_base),
        .in_hblank           (in_hblank),
        .in_vblank           (in_vblank),
        .cpu_write_enable    (cpu_write_enable),
        .cpu_address         (cpu_address),
        .cpu_data            (cpu_data),
        .cpu_busy            (cpu_busy),
        .mem_address         (mem_address),
        .mem_read            (mem_read),
        .mem_data            (mem_data),
        .mem_ready           (mem_ready),
        .periph_write_enable (periph_write_enable),
        .periph_address      (periph_address),
        .periph_data         (periph_data),
        .overrun             (overrun)
    );

    always #5 raw_clk = ~raw_clk;

    // Zero-wait memory: acknowledge in the first request cycle.
    assign mem_ready = mem_read;
    assign mem_data  = mem_model[mem_address];

    int cyc = 0;
    always @(posedge raw_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
        logic [5:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_lat;
    } cpu_vec_t;
    cpu_vec_t vecs [4];

    int c, h;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [7:0] d, input int cc);
        wr_t e;
        e.a = a;
        e.d = d;
        e.c = cc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic drive_at(input int cc);
        while (cyc < cc) step();
    endtask

    task automatic sample_at(input int cc);
        do @(negedge raw_clk); while (cyc < cc);
    endtask

    task automatic start_line(output int hh);
        step();
        in_hblank = 1'b1;
        hh = cyc;
    endtask

    task automatic pulse_vblank();
        step();
        in_vblank = 1'b1;
        step();
        in_vblank = 1'b0;
    endtask

    always @(negedge raw_clk) begin
        if (!reset && periph_write_enable) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h at cycle %0d, expected no write",
                         periph_address, periph_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(periph_address), 32'(mon_e.a));
                check("write_data", 32'(periph_data), 32'(mon_e.d));
                check("write_cycle", cyc, mon_e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'h06, 8'h42, 6'h06, 8'h42, 1};
        vecs[1] = '{6'h3f, 8'hff, 6'h3f, 8'hff, 1};
        vecs[2] = '{6'h00, 8'h00, 6'h00, 8'h00, 1};
        vecs[3] = '{6'h15, 8'ha5, 6'h15, 8'ha5, 1};

        for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
        mem_model[16'h1000] = 8'h08; mem_model[16'h1001] = 8'h1e;
        mem_model[16'h1002] = 8'h89; mem_model[16'h1003] = 8'h00;
        mem_model[16'h1004] = 8'h40; mem_model[16'h1005] = 8'h77;
        mem_model[16'h1006] = 8'h86; mem_model[16'h1007] = 8'h55;
        mem_model[16'h1008] = 8'h01; mem_model[16'h1009] = 8'ha1;
        mem_model[16'h100a] = 8'h02; mem_model[16'h100b] = 8'ha2;
        mem_model[16'h100c] = 8'h83; mem_model[16'h100d] = 8'ha3;
        mem_model[16'h100e] = 8'h84; mem_model[16'h100f] = 8'hb4;
        for (int k = 0; k < 10; k++) begin
            mem_model[16'h1010 + 2 * k]     = (k == 9 ? 8'h80 : 8'h00) | 8'(8'h10 + k);
            mem_model[16'h1010 + 2 * k + 1] = 8'(8'h30 + k);
        end
        mem_model[16'h1024] = 8'h85; mem_model[16'h1025] = 8'hc5;
        mem_model[16'h1026] = 8'h0a; mem_model[16'h1027] = 8'h11;
        mem_model[16'h1028] = 8'h8b; mem_model[16'h1029] = 8'h22;

        reset            = 1'b1;
        list_enable      = 1'b1;
        list_base        = 16'h1000;
        in_hblank        = 1'b0;
        in_vblank        = 1'b0;
        cpu_write_enable = 1'b0;
        cpu_address      = 6'h00;
        cpu_data         = 8'h00;

        repeat (3) @(posedge raw_clk);
        @(negedge raw_clk);
        check("reset_cpu_busy", 32'(cpu_busy), 0);
        check("reset_mem_read", 32'(mem_read), 0);
        check("reset_mem_address", 32'(mem_address), 0);
        check("reset_periph_we", 32'(periph_write_enable), 0);
        check("reset_periph_address", 32'(periph_address), 0);
        check("reset_periph_data", 32'(periph_data), 0);
        check("reset_overrun", 32'(overrun), 0);
        step();
        reset = 1'b0;

        // CPU writes through an idle engine
        for (int i = 0; i < 4; i++) begin
            step();
            c = cyc;
            cpu_write_enable = 1'b1;
            cpu_address      = vecs[i].addr;
            cpu_data         = vecs[i].data;
            push(vecs[i].exp_addr, vecs[i].exp_data, c + vecs[i].exp_lat);
            step();
            cpu_write_enable = 1'b0;
            sample_at(c + 1);
            check("cpu_busy_held", 32'(cpu_busy), 1);
            sample_at(c + 2);
            check("cpu_busy_released", 32'(cpu_busy), 0);
            check("periph_we_single", 32'(periph_write_enable), 0);
            check("periph_address_hold", 32'(periph_address), 32'(vecs[i].exp_addr));
            check("periph_data_hold", 32'(periph_data), 32'(vecs[i].exp_data));
        end

        // Two-entry list
        pulse_vblank();
        step();
        start_line(h);
        push(6'h08, 8'h1e, h + 3);
        push(6'h09, 8'h00, h + 6);
        sample_at(h + 1);
        check("list_mem_read_h1", 32'(mem_read), 1);
        check("list_addr_h1", 32'(mem_address), 32'h1000);
        sample_at(h + 2);
        check("list_mem_read_h2", 32'(mem_read), 1);
        check("list_addr_h2", 32'(mem_address), 32'h1001);
        sample_at(h + 7);
        check("list_idle", 32'(mem_read), 0);
        drive_at(h + 8);
        in_hblank = 1'b0;

        // NOP entry still advances the pointer
        step();
        start_line(h);
        push(6'h06, 8'h55, h + 6);
        sample_at(h + 1);
        check("nop_addr_h1", 32'(mem_address), 32'h1004);
        sample_at(h + 7);
        check("nop_idle", 32'(mem_read), 0);
        drive_at(h + 8);
        in_hblank = 1'b0;

        // hblank drops after the first write: drain the rest of the line
        step();
        start_line(h);
        push(6'h01, 8'ha1, h + 3);
        sample_at(h + 1);
        check("drain_addr_h1", 32'(mem_address), 32'h1008);
        sample_at(h + 2);
        check("drain_overrun_before", 32'(overrun), 0);
        drive_at(h + 3);
        in_hblank = 1'b0;
        sample_at(h + 5);
        check("drain_overrun_set", 32'(overrun), 1);
        sample_at(h + 10);
        check("drain_idle", 32'(mem_read), 0);
        start_line(h);
        push(6'h04, 8'hb4, h + 3);
        sample_at(h + 1);
        check("after_drain_addr", 32'(mem_address), 32'h100e);
        sample_at(h + 4);
        check("overrun_sticky", 32'(overrun), 1);
        drive_at(h + 5);
        in_hblank = 1'b0;

        // Ten writes on one line, capped at eight
        list_base = 16'h1010;
        pulse_vblank();
        @(negedge raw_clk);
        check("vblank_clears_overrun", 32'(overrun), 0);
        step();
        start_line(h);
        for (int k = 0; k < 8; k++) push(6'(6'h10 + k), 8'(8'h30 + k), h + 3 + 3 * k);
        sample_at(h + 1);
        check("cap_addr_h1", 32'(mem_address), 32'h1010);
        sample_at(h + 26);
        check("cap_overrun_early", 32'(overrun), 0);
        sample_at(h + 28);
        check("cap_addr_last", 32'(mem_address), 32'h1022);
        check("cap_overrun_set", 32'(overrun), 1);
        sample_at(h + 31);
        check("cap_idle", 32'(mem_read), 0);
        drive_at(h + 32);
        in_hblank = 1'b0;

        // CPU write colliding with an engine WRITE, plus a dropped write while busy
        step();
        start_line(h);
        push(6'h05, 8'hc5, h + 3);
        push(6'h2a, 8'h5a, h + 4);
        sample_at(h + 1);
        check("collide_addr_h1", 32'(mem_address), 32'h1024);
        drive_at(h + 2);
        cpu_write_enable = 1'b1;
        cpu_address      = 6'h2a;
        cpu_data         = 8'h5a;
        drive_at(h + 3);
        cpu_address      = 6'h3b;
        cpu_data         = 8'h6b;
        sample_at(h + 3);
        check("collide_busy_h3", 32'(cpu_busy), 1);
        drive_at(h + 4);
        cpu_write_enable = 1'b0;
        sample_at(h + 4);
        check("collide_busy_h4", 32'(cpu_busy), 1);
        sample_at(h + 5);
        check("collide_busy_h5", 32'(cpu_busy), 0);
        drive_at(h + 6);
        in_hblank = 1'b0;

        // vblank rise mid-fetch aborts and reloads
        list_base = 16'h1000;
        step();
        start_line(h);
        drive_at(h + 1);
        in_vblank = 1'b1;
        sample_at(h + 1);
        check("abort_addr_h1", 32'(mem_address), 32'h1026);
        check("abort_overrun_before", 32'(overrun), 1);
        drive_at(h + 2);
        in_vblank = 1'b0;
        sample_at(h + 2);
        check("abort_idle", 32'(mem_read), 0);
        check("abort_overrun_cleared", 32'(overrun), 0);
        drive_at(h + 3);
        in_hblank = 1'b0;
        sample_at(h + 5);
        check("abort_no_drain_overrun", 32'(overrun), 0);
        start_line(h);
        push(6'h08, 8'h1e, h + 3);
        push(6'h09, 8'h00, h + 6);
        sample_at(h + 1);
        check("reload_addr_h1", 32'(mem_address), 32'h1000);
        sample_at(h + 7);
        check("reload_idle", 32'(mem_read), 0);
        drive_at(h + 8);
        in_hblank = 1'b0;

        repeat (5) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
